lc3_mem_access: RTL and testbench

Memory-access stage responder for the LC3 pipeline. Consumes the controller's `mem_state` encoding and the execute-stage address/data, runs the request/acknowledge handshake with data memory, and returns `complete_data` and load data to the pipeline. Handles the two-phase indirect (LDI/STI) sequence by latching the pointer between phases.

---
 rtl/lc3_mem_pkg.sv | 20 ++
 rtl/lc3_mem_timeout_ctr.sv | 31 +++
 rtl/lc3_mem_access.sv | 171 +++++++++++++++++
 tb/tb_lc3_mem_access.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC3 memory-access stage.
// Used by lc3_mem_access and lc3_mem_timeout_ctr.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        MEM_LD   = 2'd0,
        MEM_IND  = 2'd1,
        MEM_ST   = 2'd2,
        MEM_IDLE = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_REQ  = 2'd1,
        FSM_DONE = 2'd2
    } mem_fsm_t;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/lc3_mem_timeout_ctr.sv
// Wait-state counter for lc3_mem_access; only built when LC3_MEM_TIMEOUT_EN is defined.
// o_hit_c fires in the REQ cycle whose un-acked end would make the count reach LIMIT.
module lc3_mem_timeout_ctr
    import lc3_mem_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit_c
);

    localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_hit_c = i_inc && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/lc3_mem_access.sv
// LC3 memory-access stage: request/ack handshake with data memory, LDI/STI pointer phase.
// Optional wait-state abort is enabled by defining LC3_MEM_TIMEOUT_EN.
module lc3_mem_access
    import lc3_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mem_state,
    input  logic        new_instr,
    input  logic [15:0] M_Addr,
    input  logic [15:0] M_Data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        complete_data,
    output logic [15:0] memout,
    output logic        timeout_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_cfg_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    mem_fsm_t    r_state,     w_state_nxt;
    mem_state_t  r_op,        w_op_nxt;
    mem_state_t  r_last_op,   w_last_op_nxt;
    logic [15:0] r_ptr,       w_ptr_nxt;
    logic        r_ind_valid, w_ind_nxt;
    logic        r_armed,     w_armed_nxt;

    logic        w_req_nxt, w_we_nxt, w_cd_nxt, w_terr_nxt;
    logic [15:0] w_addr_nxt, w_wdata_nxt, w_memout_nxt;

    mem_state_t  w_ms;
    logic        w_arm;
    logic        w_start;
    logic        w_tmo_hit_c;

    assign w_ms    = mem_state_t'(mem_state);
    // A held mem_state only re-triggers after a new_instr pulse or an idle visit.
    assign w_arm   = r_armed || new_instr || (w_ms == MEM_IDLE) || (w_ms != r_last_op);
    assign w_start = (r_state == FSM_IDLE) && (w_ms != MEM_IDLE) && w_arm;

`ifdef LC3_MEM_TIMEOUT_EN
    logic w_tmo_clr;
    logic w_tmo_inc;

    assign w_tmo_clr = w_start;
    assign w_tmo_inc = (r_state == FSM_REQ) && !dmem_ack;

    lc3_mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_tmo_clr),
        .i_inc   (w_tmo_inc),
        .o_hit_c (w_tmo_hit_c)
    );
`else
    assign w_tmo_hit_c = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_last_op_nxt = r_last_op;
        w_ptr_nxt     = r_ptr;
        w_ind_nxt     = r_ind_valid;
        w_armed_nxt   = r_armed;
        w_req_nxt     = dmem_req;
        w_we_nxt      = dmem_we;
        w_addr_nxt    = dmem_addr;
        w_wdata_nxt   = dmem_wdata;
        w_cd_nxt      = 1'b0;
        w_memout_nxt  = memout;
        w_terr_nxt    = timeout_err;

        case (r_state)
            FSM_IDLE: begin
                if (w_start) begin
                    w_state_nxt = FSM_REQ;
                    w_op_nxt    = w_ms;
                    w_addr_nxt  = r_ind_valid ? r_ptr : M_Addr;
                    w_wdata_nxt = M_Data;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = (w_ms == MEM_ST);
                    w_armed_nxt = 1'b0;
                    w_ind_nxt   = 1'b0;
                end else begin
                    if (new_instr || (w_ms == MEM_IDLE)) begin
                        w_armed_nxt = 1'b1;
                    end
                    if (w_ms == MEM_IDLE) begin
                        w_ind_nxt = 1'b0;
                    end
                end
            end
            FSM_REQ: begin
                if (dmem_ack) begin
                    if (r_op == MEM_LD) begin
                        w_memout_nxt = dmem_rdata;
                    end
                    if (r_op == MEM_IND) begin
                        w_ptr_nxt = dmem_rdata;
                        w_ind_nxt = 1'b1;
                    end
                    w_state_nxt   = FSM_DONE;
                    w_last_op_nxt = r_op;
                    w_req_nxt     = 1'b0;
                    w_we_nxt      = 1'b0;
                    w_cd_nxt      = 1'b1;
                end else if (w_tmo_hit_c) begin
                    w_state_nxt   = FSM_DONE;
                    w_last_op_nxt = r_op;
                    w_req_nxt     = 1'b0;
                    w_we_nxt      = 1'b0;
                    w_cd_nxt      = 1'b1;
                    w_memout_nxt  = 16'h0000;
                    w_ind_nxt     = 1'b0;
                    w_terr_nxt    = 1'b1;
                end
            end
            FSM_DONE: begin
                w_state_nxt = FSM_IDLE;
            end
            default: begin
                w_state_nxt = FSM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= FSM_IDLE;
            r_op          <= MEM_IDLE;
            r_last_op     <= MEM_IDLE;
            r_ptr         <= 16'h0000;
            r_ind_valid   <= 1'b0;
            r_armed       <= 1'b1;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 16'h0000;
            dmem_wdata    <= 16'h0000;
            complete_data <= 1'b0;
            memout        <= 16'h0000;
            timeout_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_op          <= w_op_nxt;
            r_last_op     <= w_last_op_nxt;
            r_ptr         <= w_ptr_nxt;
            r_ind_valid   <= w_ind_nxt;
            r_armed       <= w_armed_nxt;
            dmem_req      <= w_req_nxt;
            dmem_we       <= w_we_nxt;
            dmem_addr     <= w_addr_nxt;
            dmem_wdata    <= w_wdata_nxt;
            complete_data <= w_cd_nxt;
            memout        <= w_memout_nxt;
            timeout_err   <= w_terr_nxt;
        end
    end

endmodule

// File: tb/tb_lc3_mem_access.sv
// Randomized bench for lc3_mem_access against a transaction-level memory model.
// Timeout cases are exercised only when LC3_MEM_TIMEOUT_EN is defined.
module tb_lc3_mem_access;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mem_state = 2'd3;
    logic        new_instr = 1'b0;
    logic [15:0] M_Addr = 16'h0000;
    logic [15:0] M_Data = 16'h0000;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [15:0] dmem_rdata = 16'h0000;
    logic        complete_data;
    logic [15:0] memout;
    logic        timeout_err;

    lc3_mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_state     (mem_state),
        .new_instr     (new_instr),
        .M_Addr        (M_Addr),
        .M_Data        (M_Data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .complete_data (complete_data),
        .memout        (memout),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] exp_memout = 16'h0000;
    logic        exp_terr   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 16'h5A5A);
    endfunction

    // One memory phase: trigger inputs already set before the posedge that starts it.
    // waits < 0 means never acknowledge.
    task automatic phase(input string tag, input logic [15:0] ea, input logic ewe,
                         input logic [15:0] ewd, input int waits, input logic [15:0] rv,
                         input logic tmo);
        int   n;
        logic bad;
        @(negedge clk);
        new_instr = 1'b0;
        check({tag, "_req"},  32'(dmem_req), 32'd1);
        check({tag, "_addr"}, 32'(dmem_addr), 32'(ea));
        check({tag, "_we"},   32'(dmem_we), 32'(ewe));
        if (ewe) check({tag, "_wdata"}, 32'(dmem_wdata), 32'(ewd));
        n   = 0;
        bad = 1'b0;
        while (dmem_req === 1'b1 && n < 200) begin
            n++;
            if (complete_data !== 1'b0 || dmem_we !== ewe || dmem_addr !== ea) bad = 1'b1;
            M_Addr    = 16'($urandom);
            M_Data    = 16'($urandom);
            new_instr = ($urandom_range(0, 3) == 0);
            if (n == waits + 1) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rv;
            end else begin
                dmem_ack   = 1'b0;
                dmem_rdata = 16'($urandom);
            end
            @(negedge clk);
        end
        dmem_ack  = 1'b0;
        new_instr = 1'b0;
        check({tag, "_req_cycles"}, 32'(n), tmo ? 32'(TMO) : 32'(waits + 1));
        check({tag, "_stable"}, 32'(bad), 32'd0);
        check({tag, "_cd_hi"}, 32'(complete_data), 32'd1);
        @(negedge clk);
        check({tag, "_cd_lo"}, 32'(complete_data), 32'd0);
    endtask

    task automatic do_ld(input string tag, input logic [15:0] a, input int w);
        logic [15:0] v;
        v = rd(a);
        mem_state = 2'd0; M_Addr = a; M_Data = 16'($urandom); new_instr = 1'b1;
        phase(tag, a, 1'b0, 16'h0, w, v, 1'b0);
        exp_memout = v;
        check({tag, "_memout"}, 32'(memout), 32'(exp_memout));
        check({tag, "_terr"}, 32'(timeout_err), 32'(exp_terr));
    endtask

    task automatic do_st(input string tag, input logic [15:0] a, input logic [15:0] d, input int w);
        mem_state = 2'd2; M_Addr = a; M_Data = d; new_instr = 1'b1;
        phase(tag, a, 1'b1, d, w, 16'($urandom), 1'b0);
        mem[a] = d;
        check({tag, "_memout"}, 32'(memout), 32'(exp_memout));
    endtask

    task automatic do_ind(input string tag, input logic [15:0] a, input logic st,
                          input logic [15:0] d, input int w1, input int w2);
        logic [15:0] p;
        p = rd(a);
        mem_state = 2'd1; M_Addr = a; M_Data = 16'($urandom); new_instr = 1'b1;
        phase({tag, "_p1"}, a, 1'b0, 16'h0, w1, p, 1'b0);
        check({tag, "_p1_memout"}, 32'(memout), 32'(exp_memout));
        mem_state = st ? 2'd2 : 2'd0;
        M_Addr = 16'($urandom); M_Data = d;
        phase({tag, "_p2"}, p, st, d, w2, rd(p), 1'b0);
        if (st) mem[p] = d;
        else    exp_memout = rd(p);
        check({tag, "_memout"}, 32'(memout), 32'(exp_memout));
    endtask

    task automatic quiet(input string tag);
        int hi;
        hi = 0;
        new_instr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (dmem_req !== 1'b0) hi++;
        end
        check({tag, "_no_retrigger"}, 32'(hi), 32'd0);
    endtask

    initial begin
        #2;
        check("rst_req",    32'(dmem_req), 32'd0);
        check("rst_we",     32'(dmem_we), 32'd0);
        check("rst_addr",   32'(dmem_addr), 32'd0);
        check("rst_wdata",  32'(dmem_wdata), 32'd0);
        check("rst_cd",     32'(complete_data), 32'd0);
        check("rst_memout", 32'(memout), 32'd0);
        check("rst_terr",   32'(timeout_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        mem[16'h3010] = 16'hBEEF;
        do_ld("ld_waits", 16'h3010, 2);
        quiet("ld_waits");
        do_st("st_zero", 16'h3020, 16'h1234, 0);
        quiet("st_zero");
        mem[16'h3000] = 16'h4000;
        mem[16'h4000] = 16'h00AA;
        do_ind("ldi", 16'h3000, 1'b0, 16'h0, 0, 0);
        check("ldi_value", 32'(memout), 32'h00AA);
        quiet("ldi");

        do_ld("ld_a", 16'h3011, 0);
        quiet("ld_a");
        do_ld("ld_b", 16'h3012, 1);
        quiet("ld_b");

        // Pointer discarded when mem_state returns to idle between phases.
        mem_state = 2'd1; M_Addr = 16'h3040; new_instr = 1'b1;
        phase("disc_p1", 16'h3040, 1'b0, 16'h0, 0, rd(16'h3040), 1'b0);
        mem_state = 2'd3;
        @(negedge clk);
        do_ld("disc_ld", 16'h3050, 1);
        quiet("disc");

        // Asynchronous reset while a request is outstanding.
        mem_state = 2'd0; M_Addr = 16'h3060; new_instr = 1'b1;
        @(negedge clk);
        new_instr = 1'b0;
        check("prerst_req", 32'(dmem_req), 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_req", 32'(dmem_req), 32'd0);
        mem_state = 2'd3;
        exp_memout = 16'h0000;
        begin
            int cd;
            cd = 0;
            repeat (3) begin
                @(negedge clk);
                if (complete_data !== 1'b0) cd++;
            end
            rst = 1'b1;
            repeat (2) begin
                @(negedge clk);
                if (complete_data !== 1'b0 || dmem_req !== 1'b0) cd++;
            end
            check("rst_no_cd", 32'(cd), 32'd0);
        end
        check("postrst_memout", 32'(memout), 32'd0);
        do_ld("postrst_ld", 16'h3061, 0);
        quiet("postrst");

        for (int i = 0; i < 40; i++) begin
            int          op, w1, w2;
            logic [15:0] a, d;
            op = $urandom_range(0, 3);
            a  = 16'h3000 + 16'($urandom_range(0, 15));
            d  = 16'($urandom);
            w1 = $urandom_range(0, 4);
            w2 = $urandom_range(0, 4);
            case (op)
                0: do_ld("r_ld", a, w1);
                1: do_st("r_st", a, d, w1);
                2: do_ind("r_ldi", a, 1'b0, d, w1, w2);
                default: do_ind("r_sti", a, 1'b1, d, w1, w2);
            endcase
            quiet("rand");
            if ($urandom_range(0, 1) == 1) begin
                mem_state = 2'd3;
                dmem_ack  = 1'b1;
                @(negedge clk);
                dmem_ack  = 1'b0;
            end
        end

`ifdef LC3_MEM_TIMEOUT_EN
        do_ld("ack_at_limit", 16'h3070, int'(TMO) - 1);
        quiet("ack_at_limit");
        mem_state = 2'd0; M_Addr = 16'h3071; new_instr = 1'b1;
        phase("tmo", 16'h3071, 1'b0, 16'h0, -1, 16'h0, 1'b1);
        exp_memout = 16'h0000;
        exp_terr   = 1'b1;
        check("tmo_memout", 32'(memout), 32'd0);
        check("tmo_terr", 32'(timeout_err), 32'd1);
        quiet("tmo");
        do_ld("tmo_sticky", 16'h3072, 0);
`else
        do_ld("long_wait", 16'h3070, 20);
        check("no_tmo_terr", 32'(timeout_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
